// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates one shared RAM port between an instruction-fetch requester and
//   a data requester. Data normally has priority. An instruction fetch that
//   has waited through STARVE_LIMIT data completions is served next.
//
//   Ports
//     CLK, nRST              clock, async active-low reset
//     iREN, iaddr            instruction read request and address
//     iwait, iload           instruction wait and read data
//     dREN, dWEN             data read / write requests
//     daddr, dstore          data address and write value
//     dwait, dload           data wait and read data
//     ramREN, ramWEN         shared RAM strobes
//     ramaddr, ramstore      shared RAM address and write data
//     ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//     err                    one-cycle pulse when the owner's access errors
//
//   state  | meaning
//   IDLE   | no owner; arbitration happens here
//   DGRANT | data requester owns the RAM port
//   IGRANT | instruction requester owns the RAM port
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int CW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DGRANT = 2'd1;
    localparam logic [1:0] IGRANT = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] starve_cnt;
    logic          dreq;
    logic          d_done;
    logic          i_done;

    assign dreq = dREN | dWEN;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        iwait      = iREN;
        dwait      = dreq;
        iload      = 32'd0;
        dload      = 32'd0;
        err        = 1'b0;
        d_done     = 1'b0;
        i_done     = 1'b0;

        case (state)
            IDLE: begin
                if (iREN && (starve_cnt == LIMIT))
                    next_state = IGRANT;
                else if (dreq)
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;   // write wins when both are high
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    case (ramstate)
                        RS_ACCESS: begin
                            dwait      = 1'b0;
                            dload      = ramload;
                            d_done     = 1'b1;
                            next_state = IDLE;
                        end
                        RS_ERROR: begin
                            err        = 1'b1;
                            next_state = IDLE;
                        end
                        default: ;
                    endcase
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    case (ramstate)
                        RS_ACCESS: begin
                            iwait      = 1'b0;
                            iload      = ramload;
                            i_done     = 1'b1;
                            next_state = IDLE;
                        end
                        RS_ERROR: begin
                            err        = 1'b1;
                            next_state = IDLE;
                        end
                        default: ;
                    endcase
                end
            end

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Counts data completions seen while a fetch is pending; errors leave it alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt <= '0;
        else if (!iREN || i_done)
            starve_cnt <= '0;
        else if (d_done && (starve_cnt != LIMIT))
            starve_cnt <= starve_cnt + CW'(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT SHALL default to 4: the number of consecutive data completions allowed while an instruction request waits.
REQ-002 CLK  in  1  Single clock; all state SHALL update on its rising edge.
REQ-003 nRST  in  1  Reset, asynchronous and active-low.
REQ-004 iREN  in  1  Instruction-fetch read request, level, held until served.
REQ-005 iaddr  in  32  Instruction address.
REQ-006 iwait  out  1  High while the instruction request is not complete.
REQ-007 iload  out  32  Instruction read data, valid in the cycle iwait is low with iREN high.
REQ-008 dREN  in  1  Data read request, level.
REQ-009 dWEN  in  1  Data write request, level.
REQ-010 daddr  in  32  Data address.
REQ-011 dstore  in  32  Data write value.
REQ-012 dwait  out  1  High while the data request is not complete.
REQ-013 dload  out  32  Data read value, valid in the cycle dwait is low with dREN high.
REQ-014 ramREN, ramWEN  out  1 each  Shared RAM read and write strobes.
REQ-015 ramaddr, ramstore  out  32 each  Shared RAM address and write data.
REQ-016 ramload  in  32  RAM read data.
REQ-017 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-018 err  out  1  One-cycle pulse when the owner's access ends in ERROR.

Function
REQ-019 The FSM SHALL have three registered states: IDLE, DGRANT and IGRANT.
REQ-020 In IDLE, if iREN=1 and starve_cnt=STARVE_LIMIT, the next state SHALL be IGRANT.
REQ-021 Otherwise in IDLE, dREN or dWEN SHALL move the FSM to DGRANT; failing that, iREN SHALL move it to IGRANT; failing both, the FSM SHALL stay in IDLE.
REQ-022 In IDLE, all RAM strobes SHALL be 0, ramaddr and ramstore SHALL be 0, and iwait=iREN and dwait=(dREN or dWEN).
REQ-023 In DGRANT, ramaddr SHALL equal daddr and ramstore SHALL equal dstore, combinationally.
REQ-024 In DGRANT, ramWEN SHALL equal dWEN, and ramREN SHALL equal dREN and not dWEN, so a write wins when both are high.
REQ-025 In IGRANT, ramaddr SHALL equal iaddr, ramREN SHALL equal iREN, ramWEN SHALL be 0 and ramstore SHALL be 0.
REQ-026 In a grant state with ramstate=ACCESS, the owner's wait SHALL be 0 for that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-027 In the same case, the owner's load output SHALL equal ramload; the non-owner's wait SHALL stay high if that requester is requesting.
REQ-028 In a grant state with ramstate FREE or BUSY, the owner's wait SHALL stay high and the state SHALL hold.
REQ-029 In a grant state with ramstate=ERROR, err SHALL be 1 for that cycle, the owner's wait SHALL stay high, and the FSM SHALL return to IDLE so the request is re-arbitrated.
REQ-030 If the owner drops its request while granted, the FSM SHALL return to IDLE on the next edge, and the RAM strobes SHALL follow the dropped request that same cycle.
REQ-031 Minimum latency: request seen in IDLE, then grant state with ACCESS on the next cycle, giving a completion 1 cycle after the request with a zero-wait RAM.
REQ-032 After each completion, one IDLE cycle SHALL separate back-to-back grants.
REQ-033 iload and dload SHALL be 0 whenever their requester is not the completing owner.
REQ-034 starve_cnt is a register of width clog2(STARVE_LIMIT+1); it SHALL increment, saturating at STARVE_LIMIT, on each data completion while iREN=1.
REQ-035 starve_cnt SHALL clear to 0 on an instruction completion or in any cycle with iREN=0.
REQ-036 An ERROR completion SHALL NOT change starve_cnt.

Reset
REQ-037 When nRST=0, the state SHALL go to IDLE and starve_cnt SHALL go to 0 immediately, regardless of CLK.
REQ-038 While in reset, outputs SHALL follow the IDLE values: RAM strobes 0, err 0, and waits equal to the request inputs.
REQ-039 Reset asserted mid-grant SHALL abandon the access, and the request SHALL be re-arbitrated after nRST rises.

Verification
REQ-040 Single instruction fetch: iREN=1, iaddr=0x100, RAM returns ACCESS immediately with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x100 in cycle 2; iwait=0 and iload=0x8C010004 in cycle 2.
REQ-041 Simultaneous requests: iREN=1 and dWEN=1 with daddr=0x200, dstore=0xDEADBEEF -> data is served first (ramWEN=1); iwait stays high until the following IGRANT ACCESS.
REQ-042 Starvation: dREN held high continuously and iREN=1, STARVE_LIMIT=4 -> after 4 data completions, IGRANT is taken even though dREN=1.
REQ-043 BUSY stretch: in DGRANT, ramstate=BUSY for 3 cycles then ACCESS -> dwait stays high for 3 cycles, goes low in the 4th, then IDLE.
REQ-044 ERROR: ramstate=ERROR in IGRANT -> err pulses for 1 cycle, iwait stays 1, and the fetch is retried through IDLE.
REQ-045 Async reset mid-DGRANT: nRST pulsed low between clock edges -> state goes to IDLE at once, strobes 0, starve_cnt 0.
